fetch_pipe: RTL

- Parametrised instruction-fetch stage with an integrated IF/ID pipeline register.
- Successor to the fixed 16-bit fetch plus IF/ID pair: adds a variable-latency instruction-memory handshake, a one-entry skid buffer, stall/flush control, branch redirect priority, and generic widths.
- Sits between the instruction memory and the decode stage of the processor core.

---
 rtl/fetch_pipe.sv | 114 +++++++++++
 1 files changed

// File: rtl/fetch_pipe.sv
// Instruction fetch with variable-latency imem handshake, one-entry skid buffer and IF/ID register.
// Latency: a response accepted at an edge appears on instr_out after that edge; a stall holds IF/ID and parks the response in the skid buffer.
module fetch_pipe #(
  parameter int unsigned             ARQ      = 16,
  parameter int unsigned             MEM_ADDR = 13,
  parameter logic [MEM_ADDR-1:0]     RESET_PC = '0,
  parameter int unsigned             PC_STEP  = 1,
  parameter logic [ARQ-1:0]          NOP      = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pc_enable,
  input  logic                stall,
  input  logic                flush,
  input  logic                branch_taken,
  input  logic [MEM_ADDR-1:0] jump_address,
  output logic [MEM_ADDR-1:0] imem_addr,
  output logic                imem_req,
  input  logic [ARQ-1:0]      imem_rdata,
  input  logic                imem_valid,
  output logic [ARQ-1:0]      instr_out,
  output logic [MEM_ADDR-1:0] pc_out,
  output logic                valid_out
);

  localparam logic [0:0] ST_REQ  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [MEM_ADDR-1:0] pc_q, pc_d;
  logic [ARQ-1:0]      skid_instr_q, skid_instr_d;
  logic [MEM_ADDR-1:0] skid_pc_q, skid_pc_d;
  logic [ARQ-1:0]      instr_q, instr_d;
  logic [MEM_ADDR-1:0] pc_out_q, pc_out_d;
  logic                valid_q, valid_d;
  logic                accept;
  logic [MEM_ADDR-1:0] pc_next;

  // A response only counts while a request is actually being driven.
  assign accept  = (state_q == ST_REQ) && pc_enable && imem_valid;
  assign pc_next = pc_q + MEM_ADDR'(PC_STEP);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    valid_d      = valid_q;
    if (branch_taken) begin
      pc_d     = jump_address;
      instr_d  = NOP;
      pc_out_d = '0;
      valid_d  = 1'b0;
      state_d  = ST_REQ;
    end else if (flush) begin
      if (accept) pc_d = pc_next;
      instr_d  = NOP;
      pc_out_d = '0;
      valid_d  = 1'b0;
      state_d  = ST_REQ;
    end else if (state_q == ST_HOLD) begin
      if (!stall) begin
        instr_d  = skid_instr_q;
        pc_out_d = skid_pc_q;
        valid_d  = 1'b1;
        state_d  = ST_REQ;
      end
    end else if (accept) begin
      pc_d = pc_next;
      if (stall) begin
        skid_instr_d = imem_rdata;
        skid_pc_d    = pc_q;
        state_d      = ST_HOLD;
      end else begin
        instr_d  = imem_rdata;
        pc_out_d = pc_q;
        valid_d  = 1'b1;
      end
    end else if (!stall) begin
      instr_d  = NOP;
      pc_out_d = '0;
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_REQ;
      pc_q         <= RESET_PC;
      skid_instr_q <= NOP;
      skid_pc_q    <= '0;
      instr_q      <= NOP;
      pc_out_q     <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
      valid_q      <= valid_d;
    end
  end

  assign imem_addr = pc_q;
  assign imem_req  = (state_q == ST_REQ) && pc_enable && rst;
  assign instr_out = instr_q;
  assign pc_out    = pc_out_q;
  assign valid_out = valid_q;

endmodule
